// File: rtl/rl_queue_reader_pkg.sv
// Shared types and helpers for the queue read-side serializer.
package rl_queue_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } queue_rd_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rl_queue_reader.sv
// Pops words from a fall-through queue and streams them out LSB beat first,
// one OBITS-wide beat per accepted handshake, reloading on the last beat.
module rl_queue_reader
  import rl_queue_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int OBITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic             q_empty_i,
  input  logic [DBITS-1:0] q_d_i,
  output logic             q_re_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [OBITS-1:0] m_data_o,
  output logic             m_last_o,
  output logic             busy_o
);

  localparam int RATIO = DBITS / OBITS;
  localparam int CW    = cnt_width(RATIO);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  if (DBITS % OBITS != 0) begin : g_ratio_check
    $error("rl_queue_reader: DBITS must be a multiple of OBITS");
  end

  queue_rd_state_t  state_q, state_d;
  logic [DBITS-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic accept_s;
  logic last_s;
  logic done_s;
  logic pop_s;

  assign accept_s = ena_i & valid_q & m_ready_i;
  assign last_s   = (cnt_q == CNT_LAST);
  assign done_s   = accept_s & last_s;
  // A pop while finishing a word lets the next word follow with no bubble.
  assign pop_s    = rst_ni & ~clr_i & ena_i & ~q_empty_i
                  & ((state_q == IDLE) | done_s);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else if (pop_s) begin
      state_d = ACTIVE;
    end else if (done_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Datapath next-state: load, shift, or retire the held word
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clr_i) begin
      word_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (pop_s) begin
      word_d  = q_d_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (done_s) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      word_d = word_q >> OBITS;
      cnt_d  = cnt_q + CW'(1);
    end else begin
      word_d  = word_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
    end
  end

  // Output decode
  always_comb begin
    q_re_o    = pop_s;
    m_valid_o = valid_q;
    m_data_o  = word_q[OBITS-1:0];
    m_last_o  = valid_q & last_s;
    busy_o    = valid_q;
  end

endmodule

// File: tb/tb_rl_queue_reader.sv
// Randomized and scenario-driven bench for rl_queue_reader against a
// beat-queue reference model.
module tb_rl_queue_reader;

  localparam int DBITS = 32;
  localparam int OBITS = 8;
  localparam int RATIO = DBITS / OBITS;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clr_i;
  logic             ena_i;
  logic             q_empty_i;
  logic [DBITS-1:0] q_d_i;
  logic             q_re_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [OBITS-1:0] m_data_o;
  logic             m_last_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DBITS-1:0] src[$];
  logic [OBITS-1:0] cur[$];
  logic [OBITS-1:0] exp_data;
  logic             pend_pop;

  always #5 clk_i = ~clk_i;

  rl_queue_reader #(.DBITS(DBITS), .OBITS(OBITS)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .ena_i     (ena_i),
    .q_empty_i (q_empty_i),
    .q_d_i     (q_d_i),
    .q_re_o    (q_re_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic cyc(input logic rst, input logic ena, input logic rdy, input logic clr);
    logic             acc;
    logic             pop;
    logic [DBITS-1:0] w;
    @(negedge clk_i);
    if (pend_pop && src.size() != 0) src.delete(0);
    pend_pop  = 1'b0;
    rst_ni    = rst;
    ena_i     = ena;
    m_ready_i = rdy;
    clr_i     = clr;
    q_empty_i = (src.size() == 0);
    q_d_i     = q_empty_i ? DBITS'($urandom) : src[0];
    if (!rst) begin
      cur.delete();
      exp_data = '0;
    end
    #1;
    acc = ena & (cur.size() != 0) & rdy;
    pop = rst & !clr & ena & (src.size() != 0)
        & ((cur.size() == 0) | (acc & (cur.size() == 1)));
    chk("q_re",  q_re_o,    pop);
    chk("valid", m_valid_o, cur.size() != 0);
    chk("data",  m_data_o,  exp_data);
    chk("last",  m_last_o,  cur.size() == 1);
    chk("busy",  busy_o,    cur.size() != 0);
    pend_pop = pop;
    if (!rst || clr) begin
      cur.delete();
      exp_data = '0;
    end else begin
      if (acc) cur.delete(0);
      if (pop) begin
        w = src[0];
        for (int i = 0; i < RATIO; i++) cur.push_back(w[i*OBITS +: OBITS]);
      end
      if (cur.size() != 0) exp_data = cur[0];
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    clr_i     = 1'b0;
    ena_i     = 1'b1;
    m_ready_i = 1'b1;
    q_empty_i = 1'b1;
    q_d_i     = '0;
    pend_pop  = 1'b0;
    exp_data  = '0;

    // Reset held with a non-empty queue, then a single word streamed out.
    src.push_back(32'hA1B2_C3D4);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (7) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Back-to-back words.
    src.push_back(32'h0403_0201);
    src.push_back(32'h0807_0605);
    repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Backpressure on the second beat.
    src.push_back(32'hA1B2_C3D4);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Clear after the first beat with more words waiting.
    src.push_back(32'hA1B2_C3D4);
    src.push_back(32'h5566_7788);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (7) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Enable gating mid-word.
    src.push_back(32'hDEAD_BEEF);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-word discards the word.
    src.push_back(32'h1234_5678);
    src.push_back(32'h9ABC_DEF0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (src.size() < 6 && $urandom_range(0, 2) == 0) src.push_back($urandom);
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 99) < 3));
    end

    repeat (20) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
